// File: rtl/ustc_psum_packer.sv
`default_nettype none
// ============================================================================
// Module   : ustc_psum_packer
// Brief    : Packs a tagged serial stream of partial products into NUM_IN-slot
//            lines of {ctrl, row, data} for the column partial-sum buffer.
//            A line closes when it fills, when the column changes, or at the
//            end of the tile.
// Options  : USTC_PACK_ROWCHK_EN - drop products with row >= M and raise a
//            sticky err flag. Undefined: every product is packed, err = 0.
// Revision : 1.0 - initial release
// ============================================================================
module ustc_psum_packer #(
  parameter int M       = 16,
  parameter int NUM_IN  = 32,
  parameter int DW_DATA = 8,
  parameter int DW_ROW  = 4,
  parameter int DW_COL  = 4,
  parameter int DW_CTRL = 2,
  parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW_DATA-1:0]        in_data,
  input  logic [DW_ROW-1:0]         in_row,
  input  logic [DW_COL-1:0]         in_col,
  input  logic                      in_last,
  output logic [DW_COL-1:0]         col,
  output logic [NUM_IN*DW_LINE-1:0] line,
  output logic                      input_en,
  output logic                      output_en,
  output logic                      err
);

  localparam int IDX_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CNT_W    = $clog2(NUM_IN + 1);
  localparam int CLOSE_BIT = DW_DATA + DW_ROW + 1;

  typedef logic [NUM_IN-1:0][DW_LINE-1:0] buf_t;

  // PEND covers the cycle where a column change left a second line to emit.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_PEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  buf_t                buf_q, buf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DW_COL-1:0]   cur_col_q, cur_col_d;
  logic                pend_last_q, pend_last_d;
  buf_t                line_q, line_d;
  logic [DW_COL-1:0]   col_q, col_d;
  logic                input_en_q, input_en_d;
  logic                output_en_q, output_en_d;
  logic                in_ready_q, in_ready_d;
  logic                err_q, err_d;

  logic                w_acc;
  logic                w_drop;
  logic [DW_LINE-1:0]  w_slot;
  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_top;
  buf_t                w_app;
  buf_t                w_old_closed;

`ifdef USTC_PACK_ROWCHK_EN
  assign w_drop = (32'(in_row) >= 32'(M));
`else
  assign w_drop = 1'b0;
`endif

  assign w_acc  = in_valid && in_ready_q;
  assign w_slot = {2'b01, in_row, in_data};
  assign w_idx  = IDX_W'(cnt_q);
  assign w_top  = IDX_W'(cnt_q - 1'b1);

  // Candidate buffers: current buffer with the new product appended, and the
  // current buffer with its highest valid slot flagged as column-closing.
  always_comb begin
    w_app               = buf_q;
    w_app[w_idx]        = w_slot;
    w_old_closed        = buf_q;
    w_old_closed[w_top][CLOSE_BIT] = 1'b1;
  end

  // Next-state, packing and emit decisions.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    cur_col_d   = cur_col_q;
    pend_last_d = pend_last_q;
    line_d      = line_q;
    col_d       = col_q;
    input_en_d  = 1'b0;
    output_en_d = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_IDLE, S_FILL: begin
        if (w_acc) begin
          if (w_drop) begin
            err_d = 1'b1;
            if (in_last) begin
              if (cnt_q != '0) begin
                line_d     = w_old_closed;
                col_d      = cur_col_q;
                input_en_d = 1'b1;
              end
              buf_d   = '0;
              cnt_d   = '0;
              state_d = S_DONE;
            end
          end else if ((cnt_q != '0) && (in_col != cur_col_q)) begin
            line_d      = w_old_closed;
            col_d       = cur_col_q;
            input_en_d  = 1'b1;
            buf_d       = '0;
            buf_d[0]    = w_slot;
            cnt_d       = CNT_W'(1);
            cur_col_d   = in_col;
            pend_last_d = in_last;
            state_d     = (in_last || (NUM_IN == 1)) ? S_PEND : S_FILL;
          end else if ((cnt_q == CNT_W'(NUM_IN - 1)) || in_last) begin
            line_d = w_app;
            if (in_last) line_d[w_idx][CLOSE_BIT] = 1'b1;
            col_d      = in_col;
            input_en_d = 1'b1;
            buf_d      = '0;
            cnt_d      = '0;
            state_d    = in_last ? S_DONE : S_IDLE;
          end else begin
            buf_d     = w_app;
            cnt_d     = cnt_q + 1'b1;
            cur_col_d = in_col;
            state_d   = S_FILL;
          end
        end
      end
      S_PEND: begin
        line_d = buf_q;
        if (pend_last_q) line_d[0][CLOSE_BIT] = 1'b1;
        col_d       = cur_col_q;
        input_en_d  = 1'b1;
        buf_d       = '0;
        cnt_d       = '0;
        pend_last_d = 1'b0;
        state_d     = pend_last_q ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        output_en_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE) || (state_d == S_FILL);
  end

  // State and registered outputs; reset discards any partial buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      cur_col_q   <= '0;
      pend_last_q <= 1'b0;
      line_q      <= '0;
      col_q       <= '0;
      input_en_q  <= 1'b0;
      output_en_q <= 1'b0;
      in_ready_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      cur_col_q   <= cur_col_d;
      pend_last_q <= pend_last_d;
      line_q      <= line_d;
      col_q       <= col_d;
      input_en_q  <= input_en_d;
      output_en_q <= output_en_d;
      in_ready_q  <= in_ready_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign line      = line_q;
  assign col       = col_q;
  assign input_en  = input_en_q;
  assign output_en = output_en_q;
  assign err       = err_q;

endmodule
`default_nettype wire
